matrix_storage_writer: RTL
==========================

Name: matrix_storage_writer

Overview:
- Storage-side consumer of the compute subsystem's write interface (write_request / write_data stream / write_done).
- Latches the header of one result matrix, writes a 3-word metadata header plus the row-major payload into that matrix's fixed-size BRAM slot, and tracks per-slot validity.
- Sits between the compute subsystem and the shared matrix BRAM write port.

Parameters:
- BLOCK_SIZE, 1152, words per matrix slot (header + payload)
- DATA_WIDTH, 32, element width
- ADDR_WIDTH, 14, BRAM word-address width
- NUM_SLOTS, 8, number of matrix slots (ids 0..NUM_SLOTS-1)
- TIMEOUT_CYCLES, 1000000, idle-beat limit (optional feature only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- write_request  in  1  start-of-write strobe, sampled only while write_ready=1
- write_ready  out  1  high in IDLE only
- write_matrix_id  in  3  destination slot
- write_rows  in  8  row count
- write_cols  in  8  column count
- write_name  in  8x[0:7]  8-byte ASCII name, unpacked array
- write_data  in  DATA_WIDTH  payload element
- write_data_valid  in  1  payload beat valid
- writer_ready  out  1  payload beat accepted when valid&&ready
- write_done  out  1  one-cycle completion pulse (success or error)
- error  out  1  one-cycle pulse concurrent with write_done on rejection or abort
- bram_wr_en  out  1  BRAM write strobe
- bram_wr_addr  out  ADDR_WIDTH  BRAM write address
- bram_wr_data  out  DATA_WIDTH  BRAM write data
- slot_valid  out  NUM_SLOTS  bit i set = slot i holds a complete matrix
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: every output 0 except write_ready=1 (reset enters IDLE); slot_valid=0; internal counters 0. Reset mid-write abandons the write; the partial slot stays invalid.
- Slot base = id*BLOCK_SIZE, computed in ADDR_WIDTH bits. Layout:
  - base+0 = {16'b0, rows, cols}
  - base+1 = {name[0],name[1],name[2],name[3]}
  - base+2 = {name[4],name[5],name[6],name[7]}
  - base+3.. = payload
- total = rows*cols, computed as 16-bit unsigned.
- FSM states: IDLE, CHECK, HDR0, HDR1, HDR2, DATA, DONE.
- IDLE → CHECK: on write_request; latch id/rows/cols/name, clear slot_valid[id]. write_request in any other state is ignored.
- CHECK (1 cycle): rejects if id>=NUM_SLOTS, total==0, or total+3>BLOCK_SIZE. On rejection: write_done=1 and error=1 for one cycle, no BRAM writes, return to IDLE. Otherwise go to HDR0.
- HDR0/HDR1/HDR2: one header word per cycle. bram_wr_en=1, address base+0/1/2. writer_ready=0.
- DATA: writer_ready=1. Each accepted beat drives bram_wr_en=1, addr=base+3+count, data=write_data on the next cycle (registered, 1-cycle latency); count increments. Gaps in write_data_valid are allowed.
- DATA → DONE: when the beat with count==total-1 is accepted, writer_ready drops in the same transition; extra beats are not accepted.
- DONE (1 cycle): write_done=1, slot_valid[id]=1, then IDLE.
- write_data_valid outside DATA is ignored; no BRAM write results.
- Max payload at defaults: 1149 elements (e.g. 33x34=1122 is accepted; 34x34=1156 is rejected).

Optional Feature:
- Macro: MATRIX_WRITER_TIMEOUT_EN.
- Defined: a cycle counter runs in DATA and resets on every accepted beat. When it reaches TIMEOUT_CYCLES, write_done=1 and error=1 pulse for one cycle, slot_valid[id] stays 0, FSM returns to IDLE.
- Not defined: DATA waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package matrix_storage_pkg holds:
  - writer_state_t enum
  - HEADER_WORDS=3 and header word offset constants
  - function slot_base(id) returning ADDR_WIDTH bits
- One natural sub-module: matrix_header_check, the combinational id/dimension/capacity validator.

Test Plan:
- id=2, 3x4, name "MATRIXAB", 12 beats 1..12 → addr 2304={0,3,4}, 2305=0x4D415452, 2306=0x49584142, 2307..2318=1..12; write_done pulse; slot_valid=8'b00000100.
- 34x34 to id=0 → no bram_wr_en; write_done and error pulse together 2 cycles after the request; slot_valid[0]=0.
- 2x2 with valid toggling every other cycle plus a 5th extra beat → exactly 4 payload writes; 5th beat not accepted (writer_ready=0).
- Overwrite valid slot 1: request → slot_valid[1]=0 from the CHECK cycle until DONE, then 1.
- rst_n low mid-DATA after 3 of 6 beats → all outputs reset, write_ready=1, slot_valid=0.
- With MATRIX_WRITER_TIMEOUT_EN and TIMEOUT_CYCLES=16: stall after 1 beat → error and write_done pulse 16 cycles later; slot stays invalid.

Source files
------------

// File: rtl/matrix_storage_writer_pkg.sv
// -----------------------------------------------------------------------------
// matrix_storage_pkg
// Shared types and constants for the matrix storage writer:
//   writer_state_t  - writer FSM state encoding
//   HEADER_WORDS    - metadata words stored ahead of each payload
//   HDR_*_OFS       - word offsets of the metadata fields inside a slot
//   slot_base()     - first BRAM word address of a matrix slot
// -----------------------------------------------------------------------------
package matrix_storage_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_HDR0  = 3'd2,
        ST_HDR1  = 3'd3,
        ST_HDR2  = 3'd4,
        ST_DATA  = 3'd5,
        ST_DONE  = 3'd6
    } writer_state_t;

    localparam int HEADER_WORDS       = 3;
    localparam int HDR_DIMS_OFS       = 0;  // {16'b0, rows, cols}
    localparam int HDR_NAME_HI_OFS    = 1;  // name bytes 0..3
    localparam int HDR_NAME_LO_OFS    = 2;  // name bytes 4..7
    localparam int SLOT_ADDR_WIDTH    = 14;

    // Slot base address; the product is formed at 32 bits and then
    // truncated to the BRAM address width.
    function automatic logic [SLOT_ADDR_WIDTH-1:0] slot_base(
        input logic [2:0]  id,
        input int unsigned block_size
    );
        logic [31:0] full;
        full = 32'(id) * block_size;
        return full[SLOT_ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/matrix_storage_writer_if.sv
// -----------------------------------------------------------------------------
// matrix_storage_writer_if
// Write interface between the compute subsystem (master) and the storage
// writer (slave).
//   write_request/write_ready        : start-of-write handshake
//   write_matrix_id/rows/cols/name   : matrix header, sampled with the request
//   write_data/write_data_valid      : payload stream, accepted on writer_ready
//   write_done/error                 : completion pulse and rejection flag
// -----------------------------------------------------------------------------
interface matrix_storage_writer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  write_request;
    logic                  write_ready;
    logic [2:0]            write_matrix_id;
    logic [7:0]            write_rows;
    logic [7:0]            write_cols;
    logic [7:0]            write_name [0:7];
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_data_valid;
    logic                  writer_ready;
    logic                  write_done;
    logic                  error;

    modport master (
        output write_request, write_matrix_id, write_rows, write_cols,
               write_name, write_data, write_data_valid,
        input  write_ready, writer_ready, write_done, error
    );

    modport slave (
        input  write_request, write_matrix_id, write_rows, write_cols,
               write_name, write_data, write_data_valid,
        output write_ready, writer_ready, write_done, error
    );
endinterface

// File: rtl/matrix_storage_writer_header_check.sv
// -----------------------------------------------------------------------------
// matrix_header_check
// Combinational validator for a latched matrix header.
//   id, rows, cols : latched header fields
//   total          : rows*cols as a 16-bit element count
//   reject         : id out of range, empty matrix, or header+payload does
//                    not fit in one slot
// -----------------------------------------------------------------------------
module matrix_header_check
    import matrix_storage_pkg::*;
#(
    parameter int NUM_SLOTS  = 8,
    parameter int BLOCK_SIZE = 1152
) (
    input  logic [2:0]  id,
    input  logic [7:0]  rows,
    input  logic [7:0]  cols,
    output logic [15:0] total,
    output logic        reject
);
    logic [31:0] words_needed;

    always_comb begin
        total        = 16'(rows) * 16'(cols);
        // Widened so that a near-65535 element count cannot wrap.
        words_needed = 32'(total) + 32'(HEADER_WORDS);
        reject       = (32'(id) >= 32'(NUM_SLOTS))
                    || (total == 16'd0)
                    || (words_needed > 32'(BLOCK_SIZE));
    end
endmodule

// File: rtl/matrix_storage_writer.sv
// -----------------------------------------------------------------------------
// matrix_storage_writer
// Consumes one result matrix from the compute write interface and stores it
// into its fixed-size BRAM slot: 3 metadata words followed by the row-major
// payload. Tracks which slots hold a complete matrix.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr (slave)        : request/header, payload stream, done/error pulses
//   bram_wr_en/addr/data : shared matrix BRAM write port
//   slot_valid        : bit i set = slot i holds a complete matrix
//   busy              : FSM is not idle
//
// Build option: MATRIX_WRITER_TIMEOUT_EN adds a payload stall timeout of
// TIMEOUT_CYCLES idle DATA cycles that aborts the write with an error.
// -----------------------------------------------------------------------------
module matrix_storage_writer
    import matrix_storage_pkg::*;
#(
    parameter int BLOCK_SIZE     = 1152,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = SLOT_ADDR_WIDTH,
    parameter int NUM_SLOTS      = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_storage_writer_if.slave wr,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic [NUM_SLOTS-1:0]  slot_valid,
    output logic                  busy
);
    // Elaboration-time sanity of the configuration.
    if (NUM_SLOTS < 1 || NUM_SLOTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("matrix_storage_writer: NUM_SLOTS must be 1..8, TIMEOUT_CYCLES >= 1");
    end

    writer_state_t         state_reg, state_next;
    logic [2:0]            id_reg;
    logic [7:0]            rows_reg, cols_reg;
    logic [7:0]            name_reg [0:7];
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [15:0]           count_reg;
    logic                  dwr_en_reg;
    logic [ADDR_WIDTH-1:0] dwr_addr_reg;
    logic [DATA_WIDTH-1:0] dwr_data_reg;
    logic                  done_reg, done_next;
    logic                  error_reg, error_next;

    logic [15:0]           total;
    logic                  reject;
    logic                  latch;
    logic                  beat;
    logic                  last_beat;
    logic                  commit;
    logic                  timed_out;

    matrix_header_check #(
        .NUM_SLOTS  (NUM_SLOTS),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_check (
        .id     (id_reg),
        .rows   (rows_reg),
        .cols   (cols_reg),
        .total  (total),
        .reject (reject)
    );

    assign wr.write_ready  = (state_reg == ST_IDLE);
    assign wr.writer_ready = (state_reg == ST_DATA);
    assign wr.write_done   = done_reg;
    assign wr.error        = error_reg;
    assign busy            = (state_reg != ST_IDLE);

    assign latch     = (state_reg == ST_IDLE) && wr.write_request;
    assign beat      = wr.writer_ready && wr.write_data_valid;
    assign last_beat = (count_reg == total - 16'd1);
    assign commit    = beat && last_beat;

`ifdef MATRIX_WRITER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer_reg;

    // Counts consecutive DATA cycles without an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg <= '0;
        end else if (state_reg != ST_DATA || beat) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    assign timed_out = (state_reg == ST_DATA) && !beat
                    && (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            error_reg <= error_next;
        end
    end

    // done/error are registered, so they appear in the cycle after the
    // terminating decision: during DONE on success, in IDLE on reject/abort.
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        error_next = 1'b0;
        case (state_reg)
            ST_IDLE:  if (wr.write_request) state_next = ST_CHECK;
            ST_CHECK: begin
                if (reject) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                    error_next = 1'b1;
                end else begin
                    state_next = ST_HDR0;
                end
            end
            ST_HDR0:  state_next = ST_HDR1;
            ST_HDR1:  state_next = ST_HDR2;
            ST_HDR2:  state_next = ST_DATA;
            ST_DATA: begin
                if (commit) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else if (timed_out) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                    error_next = 1'b1;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- header latch ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_reg   <= '0;
            rows_reg <= '0;
            cols_reg <= '0;
            base_reg <= '0;
        end else if (latch) begin
            id_reg   <= wr.write_matrix_id;
            rows_reg <= wr.write_rows;
            cols_reg <= wr.write_cols;
            base_reg <= ADDR_WIDTH'(slot_base(wr.write_matrix_id, BLOCK_SIZE));
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_name
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                name_reg[gi] <= '0;
            end else if (latch) begin
                name_reg[gi] <= wr.write_name[gi];
            end
        end
    end

    // ---------------- payload path ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            dwr_en_reg   <= 1'b0;
            dwr_addr_reg <= '0;
            dwr_data_reg <= '0;
        end else begin
            dwr_en_reg <= beat;
            if (latch) begin
                count_reg <= '0;
            end else if (beat) begin
                count_reg <= count_reg + 16'd1;
            end
            if (beat) begin
                dwr_addr_reg <= base_reg + ADDR_WIDTH'(HEADER_WORDS)
                              + ADDR_WIDTH'(count_reg);
                dwr_data_reg <= wr.write_data;
            end
        end
    end

    // Header words are driven straight from the state; payload words come
    // from the one-cycle-delayed beat registers. The two never overlap
    // because beats are only accepted after HDR2.
    always_comb begin
        bram_wr_en   = dwr_en_reg;
        bram_wr_addr = dwr_addr_reg;
        bram_wr_data = dwr_data_reg;
        case (state_reg)
            ST_HDR0: begin
                bram_wr_en   = 1'b1;
                bram_wr_addr = base_reg + ADDR_WIDTH'(HDR_DIMS_OFS);
                bram_wr_data = DATA_WIDTH'({rows_reg, cols_reg});
            end
            ST_HDR1: begin
                bram_wr_en   = 1'b1;
                bram_wr_addr = base_reg + ADDR_WIDTH'(HDR_NAME_HI_OFS);
                bram_wr_data = DATA_WIDTH'({name_reg[0], name_reg[1],
                                            name_reg[2], name_reg[3]});
            end
            ST_HDR2: begin
                bram_wr_en   = 1'b1;
                bram_wr_addr = base_reg + ADDR_WIDTH'(HDR_NAME_LO_OFS);
                bram_wr_data = DATA_WIDTH'({name_reg[4], name_reg[5],
                                            name_reg[6], name_reg[7]});
            end
            default: ;
        endcase
    end

    // ---------------- slot validity ----------------
    // A slot is invalidated as soon as a write to it is requested and only
    // becomes valid again when its last payload beat is accepted.
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_valid[gi] <= 1'b0;
            end else if (latch && (wr.write_matrix_id == 3'(gi))) begin
                slot_valid[gi] <= 1'b0;
            end else if (commit && (id_reg == 3'(gi))) begin
                slot_valid[gi] <= 1'b1;
            end
        end
    end

endmodule
